// File: rtl/fetch_sequencer_if.sv
// Bundle of fetch sequencer control, instruction-memory and status signals.
// Pure wiring, no latency.
// imem side is a req/ack read: req held until ack, no other backpressure.
interface fetch_sequencer_if #(
    parameter int ADDR_W = 16
);
    logic              start;
    logic              imem_ack;
    logic [31:0]       imem_rdata;
    logic              branch_valid;
    logic [ADDR_W-1:0] branch_target;
    logic              halt;
    logic [ADDR_W-1:0] fetch_address;
    logic              imem_req;
    logic [31:0]       instr;
    logic              instr_valid;
    logic              busy;
    logic              halted;

    // Sequencer side
    modport master (
        input  start,
        input  imem_ack,
        input  imem_rdata,
        input  branch_valid,
        input  branch_target,
        input  halt,
        output fetch_address,
        output imem_req,
        output instr,
        output instr_valid,
        output busy,
        output halted
    );

    // Environment side: memory, execute path and controller
    modport slave (
        output start,
        output imem_ack,
        output imem_rdata,
        output branch_valid,
        output branch_target,
        output halt,
        input  fetch_address,
        input  imem_req,
        input  instr,
        input  instr_valid,
        input  busy,
        input  halted
    );
endinterface

// File: rtl/fetch_sequencer.sv
// PC owner and FETCH->EXEC sequencer with branch redirect and halt.
// Latency: ack at edge N gives instr_valid in cycle N+1; EXEC lasts EXEC_CYCLES.
// Backpressure: imem_req held for all of FETCH until imem_ack, no timeout.
module fetch_sequencer #(
    parameter int                ADDR_W      = 16,
    parameter logic [ADDR_W-1:0] RESET_ADDR  = '0,
    parameter int                EXEC_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    fetch_sequencer_if.master   bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FETCH  = 2'd1;
    localparam logic [1:0] S_EXEC   = 2'd2;
    localparam logic [1:0] S_HALTED = 2'd3;

    // Counter only needs to reach EXEC_CYCLES-1
    localparam int              CNT_W    = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(EXEC_CYCLES - 1);

    logic [1:0]        state;
    logic [ADDR_W-1:0] pc;
    logic [31:0]       instr_q;
    logic [CNT_W-1:0]  cnt;
    logic              exec_last;

    // Redirect and halt are only looked at on the final EXEC cycle
    assign exec_last = (state == S_EXEC) && (cnt == LAST_CNT);

    // State, PC, instruction latch and EXEC cycle counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            pc      <= RESET_ADDR;
            instr_q <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                S_IDLE, S_HALTED: begin
                    if (bus.start) begin
                        state <= S_FETCH;
                        pc    <= RESET_ADDR;
                    end
                end
                S_FETCH: begin
                    if (bus.imem_ack) begin
                        instr_q <= bus.imem_rdata;
                        cnt     <= '0;
                        state   <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (exec_last) begin
                        if (bus.halt) begin
                            // halt wins over a simultaneous branch; PC stays put
                            state <= S_HALTED;
                        end else if (bus.branch_valid) begin
                            pc    <= bus.branch_target;
                            state <= S_FETCH;
                        end else begin
                            // natural wrap modulo 2**ADDR_W
                            pc    <= pc + 1'b1;
                            state <= S_FETCH;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Outputs are registers or pure state decodes, so async reset clears them at once
    assign bus.fetch_address = pc;
    assign bus.instr         = instr_q;
    assign bus.imem_req      = (state == S_FETCH);
    assign bus.instr_valid   = (state == S_EXEC) && (cnt == '0);
    assign bus.busy          = (state == S_FETCH) || (state == S_EXEC);
    assign bus.halted        = (state == S_HALTED);
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with EXEC_CYCLES=1 and EXEC_CYCLES=3 instances.
// Inputs driven and outputs sampled 1 time unit after the rising edge.
// Memory model returns a word derived from the fetch address.
module tb_fetch_sequencer;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    fetch_sequencer_if #(.ADDR_W(16)) bus_a ();
    fetch_sequencer_if #(.ADDR_W(16)) bus_b ();

    fetch_sequencer #(.ADDR_W(16), .RESET_ADDR(16'h0000), .EXEC_CYCLES(1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    fetch_sequencer #(.ADDR_W(16), .RESET_ADDR(16'h0000), .EXEC_CYCLES(3)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [15:0] a);
        return 32'hA5C3_0000 | {16'h0000, a};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One instruction on dut_a: entered in FETCH at address a, leaves after the EXEC edge
    task automatic do_instr(input logic [15:0] a, input logic br, input logic [15:0] tgt,
                            input logic hl, input int dly);
        check("fetch_req", 32'(bus_a.imem_req), 32'd1);
        check("fetch_addr", 32'(bus_a.fetch_address), 32'(a));
        for (int i = 0; i < dly; i++) begin
            tick();
            check("wait_req", 32'(bus_a.imem_req), 32'd1);
            check("wait_addr", 32'(bus_a.fetch_address), 32'(a));
            check("wait_no_valid", 32'(bus_a.instr_valid), 32'd0);
        end
        bus_a.imem_ack   = 1'b1;
        bus_a.imem_rdata = word_at(a);
        tick();
        bus_a.imem_ack   = 1'b0;
        bus_a.imem_rdata = 32'h0;
        check("exec_valid", 32'(bus_a.instr_valid), 32'd1);
        check("exec_instr", bus_a.instr, word_at(a));
        check("exec_req", 32'(bus_a.imem_req), 32'd0);
        bus_a.branch_valid  = br;
        bus_a.branch_target = tgt;
        bus_a.halt          = hl;
        tick();
        bus_a.branch_valid  = 1'b0;
        bus_a.branch_target = 16'h0;
        bus_a.halt          = 1'b0;
    endtask

    initial begin
        bus_a.start = 1'b0; bus_a.imem_ack = 1'b0; bus_a.imem_rdata = 32'h0;
        bus_a.branch_valid = 1'b0; bus_a.branch_target = 16'h0; bus_a.halt = 1'b0;
        bus_b.start = 1'b0; bus_b.imem_ack = 1'b0; bus_b.imem_rdata = 32'h0;
        bus_b.branch_valid = 1'b0; bus_b.branch_target = 16'h0; bus_b.halt = 1'b0;

        // Reset values
        #12;
        check("rst_addr", 32'(bus_a.fetch_address), 32'h0);
        check("rst_req", 32'(bus_a.imem_req), 32'd0);
        check("rst_busy", 32'(bus_a.busy), 32'd0);
        check("rst_halted", 32'(bus_a.halted), 32'd0);
        check("rst_instr", bus_a.instr, 32'h0);
        check("rst_valid", 32'(bus_a.instr_valid), 32'd0);
        check("rst_b_busy", 32'(bus_b.busy), 32'd0);
        rst_n = 1'b1;
        tick();
        check("idle_busy", 32'(bus_a.busy), 32'd0);

        // Sequential walk 0..7
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        check("start_busy", 32'(bus_a.busy), 32'd1);
        for (int a = 0; a < 8; a++) do_instr(16'(a), 1'b0, 16'h0, 1'b0, 0);

        // Redirects: 8 -> 3 -> 0x0040 -> 5, then halt beats branch at 5
        do_instr(16'h0008, 1'b1, 16'h0003, 1'b0, 0);
        do_instr(16'h0003, 1'b1, 16'h0040, 1'b0, 0);
        do_instr(16'h0040, 1'b1, 16'h0005, 1'b0, 0);
        do_instr(16'h0005, 1'b1, 16'h0099, 1'b1, 0);
        check("halt_halted", 32'(bus_a.halted), 32'd1);
        check("halt_busy", 32'(bus_a.busy), 32'd0);
        check("halt_addr", 32'(bus_a.fetch_address), 32'h5);
        check("halt_req", 32'(bus_a.imem_req), 32'd0);

        // Ack outside FETCH must not touch instr
        bus_a.imem_ack   = 1'b1;
        bus_a.imem_rdata = 32'hDEAD_BEEF;
        tick();
        bus_a.imem_ack   = 1'b0;
        bus_a.imem_rdata = 32'h0;
        check("stray_ack_instr", bus_a.instr, word_at(16'h0005));
        check("stray_ack_halted", 32'(bus_a.halted), 32'd1);

        // Restart from HALTED, jump to all-ones, delayed ack, wrap to 0
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        check("restart_halted", 32'(bus_a.halted), 32'd0);
        do_instr(16'h0000, 1'b1, 16'hFFFF, 1'b0, 0);
        do_instr(16'hFFFF, 1'b0, 16'h0000, 1'b0, 4);
        do_instr(16'h0000, 1'b0, 16'h0000, 1'b0, 0);
        check("pre_rst_addr", 32'(bus_a.fetch_address), 32'h1);

        // Async reset mid-FETCH
        #2 rst_n = 1'b0;
        #1;
        check("rstf_req", 32'(bus_a.imem_req), 32'd0);
        check("rstf_busy", 32'(bus_a.busy), 32'd0);
        check("rstf_addr", 32'(bus_a.fetch_address), 32'h0);
        check("rstf_instr", bus_a.instr, 32'h0);
        #2 rst_n = 1'b1;
        tick();
        check("rstf_idle", 32'(bus_a.busy), 32'd0);
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        check("rstf_restart_addr", 32'(bus_a.fetch_address), 32'h0);
        check("rstf_restart_req", 32'(bus_a.imem_req), 32'd1);

        // Async reset mid-EXEC
        bus_a.imem_ack   = 1'b1;
        bus_a.imem_rdata = word_at(16'h0000);
        tick();
        bus_a.imem_ack   = 1'b0;
        check("rste_valid_pre", 32'(bus_a.instr_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rste_valid", 32'(bus_a.instr_valid), 32'd0);
        check("rste_busy", 32'(bus_a.busy), 32'd0);
        check("rste_instr", bus_a.instr, 32'h0);
        #2 rst_n = 1'b1;
        tick();
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        do_instr(16'h0000, 1'b0, 16'h0, 1'b0, 0);
        check("rste_next_addr", 32'(bus_a.fetch_address), 32'h1);

        // EXEC_CYCLES=3: plain instruction takes three EXEC cycles
        bus_b.start = 1'b1;
        tick();
        bus_b.start = 1'b0;
        check("b_req", 32'(bus_b.imem_req), 32'd1);
        check("b_addr0", 32'(bus_b.fetch_address), 32'h0);
        bus_b.imem_ack   = 1'b1;
        bus_b.imem_rdata = 32'h1234_0001;
        tick();
        bus_b.imem_ack   = 1'b0;
        check("b_valid_c1", 32'(bus_b.instr_valid), 32'd1);
        check("b_instr", bus_b.instr, 32'h1234_0001);
        tick();
        check("b_valid_c2", 32'(bus_b.instr_valid), 32'd0);
        check("b_busy_c2", 32'(bus_b.busy), 32'd1);
        check("b_req_c2", 32'(bus_b.imem_req), 32'd0);
        tick();
        check("b_valid_c3", 32'(bus_b.instr_valid), 32'd0);
        check("b_req_c3", 32'(bus_b.imem_req), 32'd0);
        tick();
        check("b_req_next", 32'(bus_b.imem_req), 32'd1);
        check("b_addr1", 32'(bus_b.fetch_address), 32'h1);

        // Halt on first EXEC cycle ignored, on last taken
        bus_b.imem_ack   = 1'b1;
        bus_b.imem_rdata = 32'h1234_0002;
        tick();
        bus_b.imem_ack   = 1'b0;
        check("b2_valid", 32'(bus_b.instr_valid), 32'd1);
        bus_b.halt = 1'b1;
        tick();
        bus_b.halt = 1'b0;
        check("b2_early_halt_ignored", 32'(bus_b.halted), 32'd0);
        check("b2_early_halt_busy", 32'(bus_b.busy), 32'd1);
        tick();
        bus_b.halt          = 1'b1;
        bus_b.branch_valid  = 1'b1;
        bus_b.branch_target = 16'h0009;
        tick();
        bus_b.halt          = 1'b0;
        bus_b.branch_valid  = 1'b0;
        check("b2_halted", 32'(bus_b.halted), 32'd1);
        check("b2_busy", 32'(bus_b.busy), 32'd0);
        check("b2_addr", 32'(bus_b.fetch_address), 32'h1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
